// File: rtl/des_round_engine.sv
// Iterative DES Feistel core: 16 rounds, one per clock, key schedule on the fly.
// Optional DES_ROUND_DEBUG_EN exposes the round counter and current subkey.
module des_round_engine (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        decrypt,
    input  logic [63:0] key_in,
    input  logic [31:0] left_in,
    input  logic [31:0] right_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] left_out,
    output logic [31:0] right_out
`ifdef DES_ROUND_DEBUG_EN
    ,
    output logic [3:0]  dbg_round,
    output logic [47:0] dbg_subkey
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

    // One entry per S-box row (box*4 + row); column 0 is the top nibble.
    localparam logic [63:0] SBOX_T [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] o;
        for (int i = 0; i < 56; i++) o[55-i] = k[64-PC1_T[i]];
        return o;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] o;
        for (int i = 0; i < 48; i++) o[47-i] = cd[56-PC2_T[i]];
        return o;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] o;
        logic [5:0]  b;
        logic [63:0] row;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int n = 0; n < 8; n++) begin
            b   = x[47-6*n -: 6];
            row = SBOX_T[n*4 + 2*int'(b[5]) + int'(b[0])];
            s[31-4*n -: 4] = row[63-4*int'(b[4:1]) -: 4];
        end
        for (int i = 0; i < 32; i++) o[31-i] = s[32-P_T[i]];
        return o;
    endfunction

    function automatic logic [27:0] rot28(input logic [27:0] v, input logic right, input logic one);
        if (right) return one ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
        else       return one ? {v[26:0], v[27]} : {v[25:0], v[27:26]};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] l_q, l_d, r_q, r_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic        mode_q, mode_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        one_shift;
    logic [27:0] c_rot, d_rot;
    logic [47:0] subkey;

    // Decrypt walks the schedule backwards: use the current C/D, then undo that round's shift.
    assign one_shift = mode_q ? (cnt_q inside {4'd0, 4'd7, 4'd14, 4'd15})
                              : (cnt_q inside {4'd0, 4'd1, 4'd8, 4'd15});
    assign c_rot  = rot28(c_q, mode_q, one_shift);
    assign d_rot  = rot28(d_q, mode_q, one_shift);
    assign subkey = mode_q ? pc2({c_q, d_q}) : pc2({c_rot, d_rot});

    always_comb begin
        state_d   = state_q;
        l_d       = l_q;
        r_d       = r_q;
        c_d       = c_q;
        d_d       = d_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    l_d        = left_in;
                    r_d        = right_in;
                    mode_d     = decrypt;
                    {c_d, d_d} = pc1(key_in);
                    cnt_d      = 4'd0;
                    state_d    = S_ROUND;
                end
            end
            S_ROUND: begin
                l_d   = r_q;
                r_d   = l_q ^ feistel(r_q, subkey);
                c_d   = c_rot;
                d_d   = d_rot;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            l_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            mode_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            c_q     <= c_d;
            d_q     <= d_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    // Final swap: R16 feeds the left half of the final permutation.
    assign left_out  = r_q;
    assign right_out = l_q;

`ifdef DES_ROUND_DEBUG_EN
    assign dbg_round  = (state_q == S_ROUND) ? cnt_q  : 4'd0;
    assign dbg_subkey = (state_q == S_ROUND) ? subkey : 48'd0;
`endif

endmodule

// File: tb/tb_des_round_engine.sv
// Scoreboard bench for des_round_engine: known DES vectors, backpressure,
// reset abort, input changes mid-block, back-to-back blocks and round trips.
module tb_des_round_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        decrypt;
    logic [63:0] key_in;
    logic [31:0] left_in;
    logic [31:0] right_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] left_out;
    logic [31:0] right_out;
`ifdef DES_ROUND_DEBUG_EN
    logic [3:0]  dbg_round;
    logic [47:0] dbg_subkey;
`endif

    always #5 clk = ~clk;

    des_round_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .decrypt   (decrypt),
        .key_in    (key_in),
        .left_in   (left_in),
        .right_in  (right_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .left_out  (left_out),
        .right_out (right_out)
`ifdef DES_ROUND_DEBUG_EN
        ,
        .dbg_round (dbg_round),
        .dbg_subkey(dbg_subkey)
`endif
    );

    localparam logic [63:0] KEY   = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_P = 64'h123556789ABDDEF0;
    localparam logic [63:0] PT    = 64'hCC00CCFF_F0AAF0AA;
    localparam logic [63:0] CT    = 64'h0A4CD995_43423234;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb_q[$];

    task automatic accept_block(input logic [63:0] key, input logic [63:0] blk, input logic dec);
        @(negedge clk);
        key_in   = key;
        left_in  = blk[63:32];
        right_in = blk[31:0];
        decrypt  = dec;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !in_ready; i++) @(negedge clk);
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) n = -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; decrypt = 1'b0;
        key_in = '0; left_in = '0; right_in = '0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        checks++; if (left_out !== 32'h0) begin errors++; $display("FAIL reset_left_out got %h exp 0", left_out); end
        checks++; if (right_out !== 32'h0) begin errors++; $display("FAIL reset_right_out got %h exp 0", right_out); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_single(input string name, input logic [63:0] key, input logic [63:0] blk,
                              input logic dec, input logic [63:0] exp);
        int n;
        logic [63:0] e;
        out_ready = 1'b1;
        sb_q.push_back(exp);
        accept_block(key, blk, dec);
        wait_valid(n);
        checks++;
        if (n != 16) begin errors++; $display("FAIL %s_latency got %0d exp 16", name, n); end
        if (n >= 0) begin
            e = sb_q.pop_front();
            checks++;
            if ({left_out, right_out} !== e) begin
                errors++; $display("FAIL %s_data got %h exp %h", name, {left_out, right_out}, e);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL %s_release out_valid=%0b in_ready=%0b exp 0/1", name, out_valid, in_ready);
            end
        end else sb_q.delete();
    endtask

    task automatic test_encrypt;
        run_single("encrypt", KEY, PT, 1'b0, CT);
    endtask

    task automatic test_decrypt;
        run_single("decrypt", KEY, CT, 1'b1, PT);
    endtask

    task automatic test_parity_ignored;
        run_single("parity", KEY_P, PT, 1'b0, CT);
    endtask

    task automatic test_backpressure;
        int n;
        logic [63:0] e;
        out_ready = 1'b0;
        sb_q.push_back(CT);
        accept_block(KEY, PT, 1'b0);
        wait_valid(n);
        checks++;
        if (n < 0) begin errors++; $display("FAIL bp_timeout out_valid=%0b exp 1", out_valid); sb_q.delete(); return; end
        e = sb_q.pop_front();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({left_out, right_out} !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got %h v=%0b r=%0b exp %h v=1 r=0", i, {left_out, right_out}, out_valid, in_ready, e);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release in_ready=%0b out_valid=%0b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_input_change;
        int n;
        logic [63:0] e;
        out_ready = 1'b1;
        sb_q.push_back(CT);
        accept_block(KEY, PT, 1'b0);
        repeat (5) @(negedge clk);
        key_in = {$urandom, $urandom}; left_in = $urandom; right_in = $urandom; decrypt = 1'b1;
        wait_valid(n);
        checks++;
        if (n < 0) begin errors++; $display("FAIL chg_timeout out_valid=%0b exp 1", out_valid); sb_q.delete(); return; end
        e = sb_q.pop_front();
        checks++;
        if ({left_out, right_out} !== e) begin
            errors++; $display("FAIL chg_data got %h exp %h", {left_out, right_out}, e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort;
        accept_block(KEY, PT, 1'b0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %0b exp 0", out_valid); end
        checks++; if ({left_out, right_out} !== 64'h0) begin errors++; $display("FAIL abort_outputs got %h exp 0", {left_out, right_out}); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready got %0b exp 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        run_single("after_abort", KEY, PT, 1'b0, CT);
    endtask

    task automatic test_back_to_back;
        logic [63:0] vblk [2];
        logic        vdec [2];
        logic [63:0] vexp [2];
        logic [63:0] e;
        int idx = 0, outs = 0, hs_cyc = -1, acc1_cyc = -1;
        bit change = 0;
        vblk[0] = PT; vdec[0] = 1'b0; vexp[0] = CT;
        vblk[1] = CT; vdec[1] = 1'b1; vexp[1] = PT;
        out_ready = 1'b1;
        @(negedge clk);
        key_in = KEY; left_in = vblk[0][63:32]; right_in = vblk[0][31:0]; decrypt = vdec[0];
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 100 && outs < 2; cyc++) begin
            change = 0;
            if (in_valid && in_ready && idx < 2) begin
                sb_q.push_back(vexp[idx]);
                if (idx == 1) acc1_cyc = cyc;
                idx++;
                change = 1;
            end
            if (out_valid) begin
                e = sb_q.pop_front();
                checks++;
                if ({left_out, right_out} !== e) begin
                    errors++; $display("FAIL b2b_data%0d got %h exp %h", outs, {left_out, right_out}, e);
                end
                if (outs == 0) hs_cyc = cyc;
                outs++;
            end
            @(negedge clk);
            if (change) begin
                if (idx == 1) begin
                    left_in = vblk[1][63:32]; right_in = vblk[1][31:0]; decrypt = vdec[1];
                end else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (outs != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", outs); end
        checks++;
        if (acc1_cyc != hs_cyc + 1) begin
            errors++; $display("FAIL b2b_accept_cycle got %0d exp %0d", acc1_cyc, hs_cyc + 1);
        end
        sb_q.delete();
    endtask

    task automatic test_roundtrip;
        int n;
        logic [63:0] key, blk, ct, e;
        out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            key = {$urandom, $urandom};
            blk = {$urandom, $urandom};
            accept_block(key, blk, 1'b0);
            wait_valid(n);
            checks++;
            if (n < 0) begin errors++; $display("FAIL rt_enc_timeout t=%0d", t); return; end
            ct = {left_out, right_out};
            @(negedge clk);
            sb_q.push_back(blk);
            accept_block(key, ct, 1'b1);
            wait_valid(n);
            checks++;
            if (n < 0) begin errors++; $display("FAIL rt_dec_timeout t=%0d", t); sb_q.delete(); return; end
            e = sb_q.pop_front();
            checks++;
            if ({left_out, right_out} !== e) begin
                errors++; $display("FAIL rt_data t=%0d got %h exp %h", t, {left_out, right_out}, e);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_parity_ignored();
        test_backpressure();
        test_input_change();
        test_reset_abort();
        test_back_to_back();
        test_roundtrip();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d exp 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/des_round_engine.md
Name: des_round_engine

Overview:
- Iterative 16-round DES Feistel core, one round per clock.
- Sits directly upstream of the final permutation stage.
- Takes the post-initial-permutation halves L0/R0 and a 64-bit key, runs the key schedule internally, and presents the pre-output halves (R16, L16) to the final permutation's left/right half inputs.
- Valid/ready handshake on both sides; encrypt and decrypt selected per block.

Parameters:
- None. DES widths and tables are fixed: PC-1, PC-2, E, P, S1–S8, shift schedule 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.

Ports:
- clk       in   1   sole clock, rising edge
- rst_n     in   1   reset
- in_valid  in   1   input block valid
- in_ready  out  1   engine can accept a block
- decrypt   in   1   0 = encrypt, 1 = decrypt; sampled on accept
- key_in    in   64  DES key, bit 63 = key bit 1, parity bits ignored by PC-1
- left_in   in   32  L0 (IP output bits 1..32)
- right_in  in   32  R0 (IP output bits 33..64)
- out_valid out  1   result valid
- out_ready in   1   downstream accepts result
- left_out  out  32  R16, drives the final permutation's left half
- right_out out  32  L16, drives the final permutation's right half

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n low, asynchronous)
  - State IDLE; in_ready=1, out_valid=0, left_out=0, right_out=0.
  - Round counter, C/D, L/R and mode registers cleared.
  - Reset mid-operation aborts the block with no output.
- FSM IDLE -> ROUND -> DONE -> IDLE
  - IDLE: in_ready=1. On in_valid&in_ready at edge T:
    - latch L=left_in, R=right_in, mode=decrypt, {C,D}=PC1(key_in) (28+28 bits);
    - round counter=0; go to ROUND.
  - ROUND: in_ready=0, out_valid=0. Each edge:
    - compute subkey K;
    - L<=R; R<=L ^ f(R,K), where f = P(S(E(R) ^ K));
    - counter increments.
    - After the edge with counter=15 (edge T+16), go to DONE.
  - DONE: out_valid=1, left_out=R, right_out=L (final swap). Outputs are registered and stable while out_valid=1.
    - On out_valid&out_ready, go to IDLE; out_valid drops the next cycle.
    - out_ready low holds DONE indefinitely with outputs unchanged.
- Key schedule, round r = counter+1
  - Encrypt: {C,D} <= rotl28 each by shift[r]; K = PC2 of the rotated values, same cycle.
  - Decrypt: K = PC2(current C,D); then {C,D} <= rotr28 each by shift[17-r]. Round 1 uses K16 = PC2(PC1(key)).
- Timing and throughput
  - Latency: accept at edge T, out_valid high in the cycle after edge T+16.
  - Minimum 18 cycles per block: no accept while ROUND or DONE.
- Inputs are ignored outside the IDLE accept. key_in and decrypt may change freely after accept.
- Bit numbering: DES bit 1 = MSB of each vector. Table entries index 1-based from MSB.
- S-box lookup: row = {b1,b6}, column = b2..b5 of each 6-bit group.

Optional Feature:
- DES_ROUND_DEBUG_EN defined:
  - Adds output ports dbg_round[3:0] (current counter, 0 outside ROUND) and dbg_subkey[47:0] (K used this cycle, 0 outside ROUND).
  - Both are combinational from registers.
- Undefined: ports absent, no other change. Functional behaviour is identical either way.

Test Plan:
- Encrypt: key 133457799BBCDFF1, left_in CC00CCFF, right_in F0AAF0AA, decrypt=0 -> out_valid exactly 16 cycles after accept, left_out 0A4CD995, right_out 43423234.
- Decrypt: same key, left_in 0A4CD995, right_in 43423234, decrypt=1 -> left_out CC00CCFF, right_out F0AAF0AA; with DES_ROUND_DEBUG_EN, round-0 dbg_subkey equals encrypt round-15 subkey.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0 throughout; raise out_ready -> in_ready=1 the following cycle.
- Input changes: change key_in, left_in and decrypt at round 5 -> result still matches the first vector.
- Reset abort: assert rst_n=0 at round 8 -> out_valid=0, outputs 0, in_ready=1 immediately. Next block completes correctly.
- Back-to-back: in_valid held high for two vectors -> second accepted the cycle after the first output handshake; both results correct.
